// File: rtl/sbrb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sbrb_pkg
// Description : Shared types and constants for the SbRb latch pulse driver.
//               FSM state encoding, default timing constants, the idle
//               output encoding and a small constant helper function.
// Revision    : 1.0 - initial release
// ============================================================================
package sbrb_pkg;

  // Driver FSM states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PULSE_S = 2'd1,
    PULSE_R = 2'd2,
    GAP     = 2'd3
  } sbrb_state_e;

  // Default timing (in clk cycles).
  localparam int SBRB_DB_CYCLES_DEF = 4;
  localparam int SBRB_PULSE_W_DEF   = 2;
  localparam int SBRB_GAP_W_DEF     = 1;

  // {sb_n, rb_n} while no pulse is being driven: latch holds its state.
  localparam logic [1:0] SBRB_HOLD = 2'b11;

  // Larger of two integers, for sizing shared counters at elaboration time.
  function automatic int sbrb_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage : sbrb_pkg
`default_nettype wire

// File: rtl/sbrb_pulse_driver_btn_debounce.sv
`default_nettype none
// ============================================================================
// Module      : btn_debounce
// Description : Two-flop synchronizer, debounce counter and press detector
//               for one raw push-button input.
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   btn_raw  in   raw asynchronous button, active high
//   press    out  one-cycle pulse, registered, on each debounced 0->1 change
// Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce
  import sbrb_pkg::*;
#(
  parameter int DB_CYCLES = SBRB_DB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic press
);

  localparam int            CW       = $clog2(DB_CYCLES + 1);
  // The level flips on the cycle that would bring the count to DB_CYCLES.
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    level_d = level_q;
    press_d = 1'b0;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        // Only rising debounced edges are reported; releases are silent.
        press_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign press = press_q;

endmodule : btn_debounce
`default_nettype wire

// File: rtl/sbrb_pulse_driver.sv
`default_nettype none
// ============================================================================
// Module      : sbrb_pulse_driver
// Description : Upstream driver for an active-low SbRb latch. Debounced set
//               and reset button presses become fixed-width active-low pulses
//               on sb_n / rb_n, separated by an all-high gap, so the latch
//               never sees sb_n = rb_n = 0. Tracks the expected latch state.
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   set_btn    in   raw set button, active high
//   rst_btn    in   raw reset button, active high
//   q_fb       in   latch Q feedback          (SBRB_QCHECK_EN only)
//   q_mismatch out  Q feedback disagrees      (SBRB_QCHECK_EN only)
//   sb_n       out  registered active-low set pulse
//   rb_n       out  registered active-low reset pulse
//   q_shadow   out  expected latch Q after the last completed pulse
//   busy       out  high while pulsing or in the gap
//   conflict   out  one-cycle flag: set and reset pressed in the same cycle
// Optional    : define SBRB_QCHECK_EN to build the latch feedback checker.
// Revision    : 1.0 - initial release
// ============================================================================
module sbrb_pulse_driver
  import sbrb_pkg::*;
#(
  parameter int DB_CYCLES = SBRB_DB_CYCLES_DEF,
  parameter int PULSE_W   = SBRB_PULSE_W_DEF,
  parameter int GAP_W     = SBRB_GAP_W_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic set_btn,
  input  logic rst_btn,
`ifdef SBRB_QCHECK_EN
  input  logic q_fb,
  output logic q_mismatch,
`endif
  output logic sb_n,
  output logic rb_n,
  output logic q_shadow,
  output logic busy,
  output logic conflict
);

  localparam int            TW         = $clog2(sbrb_max(PULSE_W, GAP_W) + 1);
  localparam logic [TW-1:0] PULSE_LAST = TW'(PULSE_W - 1);
  localparam logic [TW-1:0] GAP_LAST   = TW'(GAP_W - 1);

  logic set_press, rst_press;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_set (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_raw (set_btn),
    .press   (set_press)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_rst (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_raw (rst_btn),
    .press   (rst_press)
  );

  sbrb_state_e   state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          set_pend_q, set_pend_d;
  logic          rst_pend_q, rst_pend_d;
  logic          sb_n_q, sb_n_d;
  logic          rb_n_q, rb_n_d;
  logic          q_shadow_q, q_shadow_d;
  logic          busy_q, busy_d;
  logic          conflict_q, conflict_d;

  always_comb begin
    // Simultaneous presses: reset wins and the set press is discarded.
    // A press onto an already-set flag is absorbed by the OR.
    conflict_d = set_press & rst_press;
    set_pend_d = set_pend_q | (set_press & ~rst_press);
    rst_pend_d = rst_pend_q | rst_press;
    state_d    = state_q;
    tmr_d      = tmr_q;
    q_shadow_d = q_shadow_q;

    case (state_q)
      IDLE: begin
        tmr_d = '0;
        // Looking at the _d flags lets a press issued this cycle start a
        // pulse on the next edge instead of waiting one cycle in the flag.
        if (rst_pend_d) begin
          state_d    = PULSE_R;
          rst_pend_d = 1'b0;
        end else if (set_pend_d) begin
          state_d    = PULSE_S;
          set_pend_d = 1'b0;
        end
      end
      PULSE_S: begin
        if (tmr_q == PULSE_LAST) begin
          state_d    = GAP;
          tmr_d      = '0;
          q_shadow_d = 1'b1;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      PULSE_R: begin
        if (tmr_q == PULSE_LAST) begin
          state_d    = GAP;
          tmr_d      = '0;
          q_shadow_d = 1'b0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      GAP: begin
        if (tmr_q == GAP_LAST) begin
          state_d = IDLE;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        tmr_d   = '0;
      end
    endcase

    // Outputs are decoded from the next state so they register together
    // with it; a single state can drive at most one line low.
    {sb_n_d, rb_n_d} = SBRB_HOLD;
    if (state_d == PULSE_S) sb_n_d = 1'b0;
    if (state_d == PULSE_R) rb_n_d = 1'b0;
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      tmr_q      <= '0;
      set_pend_q <= 1'b0;
      rst_pend_q <= 1'b0;
      sb_n_q     <= 1'b1;
      rb_n_q     <= 1'b1;
      q_shadow_q <= 1'b0;
      busy_q     <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      set_pend_q <= set_pend_d;
      rst_pend_q <= rst_pend_d;
      sb_n_q     <= sb_n_d;
      rb_n_q     <= rb_n_d;
      q_shadow_q <= q_shadow_d;
      busy_q     <= busy_d;
      conflict_q <= conflict_d;
    end
  end

  assign sb_n     = sb_n_q;
  assign rb_n     = rb_n_q;
  assign q_shadow = q_shadow_q;
  assign busy     = busy_q;
  assign conflict = conflict_q;

`ifdef SBRB_QCHECK_EN
  // Latch feedback checker. The feedback is only trusted after two IDLE
  // cycles so the synchronizer has caught up with the last pulse.
  logic       qfb_s1_q, qfb_s2_q;
  logic [1:0] idle_cnt_q, idle_cnt_d;
  logic       q_mismatch_q, q_mismatch_d;

  always_comb begin
    idle_cnt_d = '0;
    if (state_q == IDLE) begin
      idle_cnt_d = (idle_cnt_q == 2'd2) ? idle_cnt_q : idle_cnt_q + 1'b1;
    end
    q_mismatch_d = (state_q == IDLE) && (state_d == IDLE) &&
                   (idle_cnt_q == 2'd2) && (qfb_s2_q != q_shadow_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qfb_s1_q     <= 1'b0;
      qfb_s2_q     <= 1'b0;
      idle_cnt_q   <= '0;
      q_mismatch_q <= 1'b0;
    end else begin
      qfb_s1_q     <= q_fb;
      qfb_s2_q     <= qfb_s1_q;
      idle_cnt_q   <= idle_cnt_d;
      q_mismatch_q <= q_mismatch_d;
    end
  end

  assign q_mismatch = q_mismatch_q;
`endif

endmodule : sbrb_pulse_driver
`default_nettype wire

// File: tb/tb_sbrb_pulse_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_sbrb_pulse_driver
// Description : Self-checking bench for sbrb_pulse_driver (default timing:
//               DB_CYCLES=4, PULSE_W=2, GAP_W=1). A cycle-level behavioural
//               model predicts every output; directed scenarios add literal
//               expectations. Define SBRB_QCHECK_EN for the feedback checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sbrb_pulse_driver;

  localparam int DB = 4;
  localparam int PW = 2;
  localparam int GW = 1;

  logic clk = 1'b0;
  logic rst_n, set_btn, rst_btn;
  logic sb_n, rb_n, q_shadow, busy, conflict;

  always #5 clk = ~clk;

`ifdef SBRB_QCHECK_EN
  logic qfb_mode;
  logic q_fb, q_mismatch;
  assign q_fb = qfb_mode ? q_shadow : 1'b0;
`endif

  sbrb_pulse_driver #(.DB_CYCLES(DB), .PULSE_W(PW), .GAP_W(GW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .set_btn    (set_btn),
    .rst_btn    (rst_btn),
`ifdef SBRB_QCHECK_EN
    .q_fb       (q_fb),
    .q_mismatch (q_mismatch),
`endif
    .sb_n       (sb_n),
    .rb_n       (rb_n),
    .q_shadow   (q_shadow),
    .busy       (busy),
    .conflict   (conflict)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------
  // Behavioural model. Debounce: a level flips once the last DB synchronized
  // samples all disagree with it. Pulse engine: one countdown covering the
  // whole pulse+gap window of the current request.
  // ---------------------------------------------------------------------
  bit m_s1 [2];
  bit m_s2 [2];
  bit m_lvl [2];
  bit m_press [2];
  bit m_hist [2][DB];
  bit m_pend_s, m_pend_r, m_q, m_conf;
  int m_left, m_kind;   // m_kind: 1 = set pulse, 2 = reset pulse

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int i = 0; i < 2; i++) begin
          m_s1[i] = 0; m_s2[i] = 0; m_lvl[i] = 0; m_press[i] = 0;
          for (int j = 0; j < DB; j++) m_hist[i][j] = 0;
        end
        m_pend_s = 0; m_pend_r = 0; m_q = 0; m_conf = 0;
        m_left = 0; m_kind = 0;
      end else begin
        bit ps, pr, sp, rp, all_diff;
        ps = m_press[0];
        pr = m_press[1];
        m_conf = ps & pr;
        if (m_left == 0) begin
          rp = m_pend_r | pr;
          sp = m_pend_s | (ps & !pr);
          if (rp) begin
            m_kind = 2; m_left = PW + GW; m_pend_r = 0; m_pend_s = sp;
          end else if (sp) begin
            m_kind = 1; m_left = PW + GW; m_pend_s = 0;
          end
        end else begin
          m_left--;
          if (m_left == GW) m_q = (m_kind == 1);
          m_pend_r = m_pend_r | pr;
          m_pend_s = m_pend_s | (ps & !pr);
        end
        for (int i = 0; i < 2; i++) begin
          for (int j = DB - 1; j > 0; j--) m_hist[i][j] = m_hist[i][j-1];
          m_hist[i][0] = m_s2[i];
          all_diff = 1;
          for (int j = 0; j < DB; j++) if (m_hist[i][j] == m_lvl[i]) all_diff = 0;
          m_press[i] = 0;
          if (all_diff) begin
            m_lvl[i]   = !m_lvl[i];
            m_press[i] = m_lvl[i];
          end
          m_s2[i] = m_s1[i];
          m_s1[i] = (i == 0) ? set_btn : rst_btn;
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Per-cycle compare plus activity counters for the directed scenarios.
  // ---------------------------------------------------------------------
  bit cmp_en = 0;
  int n_sb_low, n_rb_low, n_conf, n_busy, n_both_low;

  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en && rst_n) begin
        check("sb_n",     sb_n,     !(m_kind == 1 && m_left > GW));
        check("rb_n",     rb_n,     !(m_kind == 2 && m_left > GW));
        check("q_shadow", q_shadow, m_q);
        check("busy",     busy,     m_left > 0);
        check("conflict", conflict, m_conf);
        if (!sb_n) n_sb_low++;
        if (!rb_n) n_rb_low++;
        if (conflict) n_conf++;
        if (busy) n_busy++;
        if (!sb_n && !rb_n) n_both_low++;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clr_counts();
    n_sb_low = 0; n_rb_low = 0; n_conf = 0; n_busy = 0; n_both_low = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    rst_n = 1'b0; set_btn = 1'b0; rst_btn = 1'b0;
`ifdef SBRB_QCHECK_EN
    qfb_mode = 1'b0;
`endif
    clr_counts();
    tick(3);
    // Reset state.
    check("rst_sb_n", sb_n, 1);
    check("rst_rb_n", rb_n, 1);
    check("rst_q", q_shadow, 0);
    check("rst_busy", busy, 0);
    check("rst_conflict", conflict, 0);
    rst_n = 1'b1;
    cmp_en = 1'b1;
    tick(2);

    // T1: clean set press; sb_n low after edges 7 and 8, q set after edge 9.
    set_btn = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      check("t1_sb_n", sb_n, (k == 7 || k == 8) ? 0 : 1);
      check("t1_rb_n", rb_n, 1);
      if (k == 9) check("t1_q", q_shadow, 1);
    end
    tick(10);
    set_btn = 1'b0;
    tick(15);

    // T2: set press, reset press 10 cycles later.
    clr_counts();
    set_btn = 1'b1; tick(10);
    rst_btn = 1'b1; tick(10);
    set_btn = 1'b0; tick(10);
    rst_btn = 1'b0; tick(15);
    check("t2_sb_cycles", n_sb_low, 2);
    check("t2_rb_cycles", n_rb_low, 2);
    check("t2_both_low", n_both_low, 0);
    check("t2_q", q_shadow, 0);

    // T3: both buttons rise together.
    clr_counts();
    set_btn = 1'b1; rst_btn = 1'b1; tick(15);
    set_btn = 1'b0; rst_btn = 1'b0; tick(15);
    check("t3_conflict", n_conf, 1);
    check("t3_sb_cycles", n_sb_low, 0);
    check("t3_rb_cycles", n_rb_low, 2);
    check("t3_q", q_shadow, 0);

    // T3b: reset press, set press 2 cycles later; set is queued behind reset.
    clr_counts();
    rst_btn = 1'b1; tick(2);
    set_btn = 1'b1; tick(20);
    rst_btn = 1'b0; set_btn = 1'b0; tick(15);
    check("t3b_rb_cycles", n_rb_low, 2);
    check("t3b_sb_cycles", n_sb_low, 2);
    check("t3b_both_low", n_both_low, 0);
    check("t3b_q", q_shadow, 1);

    // T4: 3-cycle glitch is filtered.
    clr_counts();
    set_btn = 1'b1; tick(3);
    set_btn = 1'b0; tick(15);
    check("t4_busy_cycles", n_busy, 0);
    check("t4_sb_cycles", n_sb_low, 0);
    check("t4_q", q_shadow, 1);

    // T5: reset during the first sb_n=0 cycle, then release.
    rst_btn = 1'b1; tick(15); rst_btn = 1'b0; tick(15);  // q back to 0 first
    set_btn = 1'b1; tick(15); set_btn = 1'b0; tick(15);  // q = 1 again
    check("t5_q_before", q_shadow, 1);
    set_btn = 1'b1;
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(posedge clk); #1;
      if (!sb_n) found = 1;
    end
    check("t5_pulse_seen", found, 1);
    #1 rst_n = 1'b0;
    #1;
    check("t5_async_sb_n", sb_n, 1);
    check("t5_async_q", q_shadow, 0);
    check("t5_async_busy", busy, 0);
    @(negedge clk);
    set_btn = 1'b0;
    tick(2);
    rst_n = 1'b1;
    clr_counts();
    tick(20);
    check("t5_no_pulse", n_sb_low, 0);
    check("t5_q_after", q_shadow, 0);

`ifdef SBRB_QCHECK_EN
    // Q6: feedback stuck at 0 after a set pulse must be flagged.
    qfb_mode = 1'b0;
    set_btn = 1'b1; tick(15); set_btn = 1'b0;
    found = 0;
    repeat (12) begin
      @(negedge clk);
      if (q_mismatch) found = 1;
    end
    check("q6_mismatch_flag", found, 1);
    // Feedback following q_shadow must never be flagged.
    qfb_mode = 1'b1;
    tick(6);
    found = 0;
    rst_btn = 1'b1;
    repeat (15) begin @(negedge clk); if (q_mismatch) found = 1; end
    rst_btn = 1'b0; set_btn = 1'b1;
    repeat (15) begin @(negedge clk); if (q_mismatch) found = 1; end
    set_btn = 1'b0;
    repeat (15) begin @(negedge clk); if (q_mismatch) found = 1; end
    check("q6_no_mismatch", found, 0);
`endif

    cmp_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_sbrb_pulse_driver
`default_nettype wire

// File: doc/sbrb_pulse_driver.md
Name: sbrb_pulse_driver

Overview:
- Upstream driver stage for the active-low SbRb latch.
- Takes two raw push-button inputs (set, reset), synchronizes and debounces them, and turns each debounced press into a fixed-width active-low pulse on sb_n or rb_n.
- Guarantees the latch never sees the forbidden Sb=Rb=0 input.
- Keeps a shadow copy of the expected latch state.

Parameters:
- DB_CYCLES, 4: consecutive stable synchronized samples required before a debounced level changes (min 1).
- PULSE_W, 2: cycles sb_n/rb_n is held low per request (min 1).
- GAP_W, 1: mandatory cycles with both outputs high after any pulse (min 1).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- set_btn  input  1  raw asynchronous set button, active high.
- rst_btn  input  1  raw asynchronous reset button, active high.
- sb_n  output  1  registered active-low set pulse to the latch.
- rb_n  output  1  registered active-low reset pulse to the latch.
- q_shadow  output  1  expected latch Q after the last completed pulse.
- busy  output  1  high while in PULSE_S, PULSE_R or GAP.
- conflict  output  1  one-cycle pulse when set and reset presses are detected in the same cycle.

Behaviour:
- Reset (async, rst_n=0):
  - sb_n=1, rb_n=1, q_shadow=0, busy=0, conflict=0.
  - Sync flops and debounced levels 0, counters 0, state IDLE, pending flags clear.
- Sync: each button passes through a 2-FF synchronizer.
- Debounce, per button:
  - Counter increments each cycle the synchronized value differs from the debounced level; it clears when they are equal.
  - When the counter reaches DB_CYCLES, the level takes the new value and the counter clears.
- Press event: 0->1 transition of a debounced level, one cycle wide. Releases generate nothing.
- Pending flags: one-deep per button, set by a press event. A press while that flag is already set is dropped.
- Simultaneous press events in the same cycle: reset wins. Set the rst pending flag, discard set, pulse conflict for 1 cycle. An already-pending set flag stays untouched.
- FSM states and transitions:
  - IDLE: if rst pending -> PULSE_R. Else if set pending -> PULSE_S. The chosen flag clears on entry. Reset has priority when both flags are set.
  - PULSE_S: sb_n=0, rb_n=1 for exactly PULSE_W cycles, then GAP; q_shadow<=1 on exit.
  - PULSE_R: rb_n=0, sb_n=1 for exactly PULSE_W cycles, then GAP; q_shadow<=0 on exit.
  - GAP: both high for GAP_W cycles, then IDLE.
- Outputs are registered from state. sb_n and rb_n are never both 0 in any cycle, including around reset.
- Latency, clean press held stable: sb_n/rb_n falls DB_CYCLES+3 rising edges after the first edge that samples the button high (2 sync + DB_CYCLES debounce + 1 FSM).
- A pulse is never truncated or extended by new presses. Presses arriving during busy are queued via the pending flags.
- Glitch shorter than DB_CYCLES synchronized cycles: no event.
- Reset asserted mid-pulse: outputs go high immediately (asynchronous). Pending requests are lost and q_shadow returns to 0.
- Pulse and gap counters are sized to clog2(max(PULSE_W, GAP_W)+1). No wrap occurs within a state.

Optional Feature:
- Macro: SBRB_QCHECK_EN.
- When defined:
  - Adds input q_fb (1 bit, from the latch Q) and output q_mismatch (1 bit, registered, reset 0).
  - q_fb passes through its own 2-FF synchronizer.
  - q_mismatch=1 in any IDLE cycle where synced q_fb != q_shadow, and only once at least 2 IDLE cycles have elapsed since GAP.
- When undefined: neither port exists and no checking logic is built.

Decomposition:
- Package sbrb_pkg:
  - State enum {IDLE, PULSE_S, PULSE_R, GAP}.
  - Default constants for DB_CYCLES/PULSE_W/GAP_W.
  - Encoding constants SBRB_HOLD (sb_n=1, rb_n=1).
- Sub-module btn_debounce (synchronizer + debounce counter + press-event output), instantiated twice.

Test Plan:
- Reset then set_btn high held 20 cycles (defaults) -> sb_n low on edge 7 after the first sample, for 2 cycles; rb_n stays 1; q_shadow=1 after the pulse.
- set press then rst press 10 cycles later -> sb_n 2-cycle pulse, then rb_n 2-cycle pulse, at least 1 all-high gap between them; q_shadow ends 0; never sb_n=rb_n=0.
- Both buttons rise in the same cycle -> conflict=1 for 1 cycle, only an rb_n pulse, q_shadow=0.
- set_btn glitch high for 3 cycles (DB_CYCLES=4) -> no pulse, busy stays 0.
- Reset asserted mid-pulse during the 1st cycle of sb_n=0 -> sb_n=1 and q_shadow=0 asynchronously; no pulse after release.
- SBRB_QCHECK_EN defined, q_fb tied 0 after a set pulse -> q_mismatch=1 by 2 IDLE cycles after GAP; with q_fb following q_shadow, q_mismatch stays 0.
